// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Run  = 2'd1,
    Done = 2'd2
  } state_e;

  // Bit counter width; never narrower than one bit so WIDTH=1 still has a register.
  function automatic int unsigned cnt_width(int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational full adder built from two half adders and an OR gate.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha0_s, ha0_c, ha1_c;

  // First half adder: a + b
  assign ha0_s = a ^ b;
  assign ha0_c = a & b;

  // Second half adder: partial sum + cin
  assign s     = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;

  assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per clock through a single full-adder
// cell, LSB first, with results registered on the final bit.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_sr_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] res_shift;

  full_adder_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New bit enters at the MSB; written as shifts so WIDTH=1 needs no special case.
  assign res_shift = (res_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= Idle;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      res_sr_q  <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_q)
        Idle, Done: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with sub.
            a_sr_q  <= a;
            b_sr_q  <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= Run;
          end else begin
            state_q <= Idle;
          end
        end
        Run: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_shift;
          carry_q  <= fa_cout;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            // carry_q here is the carry into the MSB.
            sum       <= res_shift;
            carry_out <= fa_cout;
            overflow  <= carry_q ^ fa_cout;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= Done;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases on WIDTH=8 plus a random
// sweep on WIDTH=1/16/64, checked against an arithmetic reference model.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] a_in, b_in;
  logic        sub_in, start;
  logic [1:0]  sel;
  logic [3:0]  start_v;

  always #5 clk = ~clk;

  always_comb begin
    start_v      = '0;
    start_v[sel] = start;
  end

  logic        busy8, done8, co8, ov8;
  logic [7:0]  sum8;
  logic        busy1, done1, co1, ov1;
  logic [0:0]  sum1;
  logic        busy16, done16, co16, ov16;
  logic [15:0] sum16;
  logic        busy64, done64, co64, ov64;
  logic [63:0] sum64;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_in), .a(a_in[7:0]), .b(b_in[7:0]),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
  );
  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_in), .a(a_in[0:0]), .b(b_in[0:0]),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1), .overflow(ov1)
  );
  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_in), .a(a_in[15:0]),
    .b(b_in[15:0]), .busy(busy16), .done(done16), .sum(sum16), .carry_out(co16),
    .overflow(ov16)
  );
  serial_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .sub(sub_in), .a(a_in), .b(b_in),
    .busy(busy64), .done(done64), .sum(sum64), .carry_out(co64), .overflow(ov64)
  );

  logic        cur_busy, cur_done, cur_co, cur_ov;
  logic [63:0] cur_sum;

  always_comb begin
    case (sel)
      2'd0: begin
        cur_busy = busy8;  cur_done = done8;  cur_sum = 64'(sum8);  cur_co = co8;  cur_ov = ov8;
      end
      2'd1: begin
        cur_busy = busy1;  cur_done = done1;  cur_sum = 64'(sum1);  cur_co = co1;  cur_ov = ov1;
      end
      2'd2: begin
        cur_busy = busy16; cur_done = done16; cur_sum = 64'(sum16); cur_co = co16; cur_ov = ov16;
      end
      default: begin
        cur_busy = busy64; cur_done = done64; cur_sum = sum64;      cur_co = co64; cur_ov = ov64;
      end
    endcase
  end

  typedef struct packed {
    logic [63:0] sum;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int width_of(logic [1:0] s);
    case (s)
      2'd0:    return 8;
      2'd1:    return 1;
      2'd2:    return 16;
      default: return 64;
    endcase
  endfunction

  // Whole-word arithmetic reference; carry into the MSB comes from the low bits alone.
  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic s);
    logic [63:0] mask, lo, am, bm;
    logic [64:0] full, part;
    exp_t e;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    lo    = mask >> 1;
    am    = a & mask;
    bm    = (s ? ~b : b) & mask;
    full  = {1'b0, am} + {1'b0, bm} + 65'(s);
    part  = {1'b0, am & lo} + {1'b0, bm & lo} + 65'(s);
    e.sum = full[63:0] & mask;
    e.co  = full[w];
    e.ov  = part[w-1] ^ full[w];
    return e;
  endfunction

  task automatic run_op(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b,
                        input logic sb_sub, input string name);
    int   w, cycles, busy_cycles;
    exp_t e;
    w      = width_of(s);
    sel    = s;
    a_in   = a;
    b_in   = b;
    sub_in = sb_sub;
    start  = 1'b1;
    sb.push_back(model(w, a, b, sb_sub));
    @(negedge clk);
    start       = 1'b0;
    cycles      = 1;
    busy_cycles = 0;
    while (!cur_done && cycles <= w + 4) begin
      if (cur_busy) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    e = sb.pop_front();
    checks++;
    if (!cur_done) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles, want %0d", name, cycles, w + 1);
      return;
    end
    checks++;
    if (cycles !== w + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, cycles, w + 1);
    end
    checks++;
    if (busy_cycles !== w) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cycles, w);
    end
    checks++;
    if (cur_sum !== e.sum || cur_co !== e.co || cur_ov !== e.ov) begin
      errors++;
      $display("FAIL %s result: got sum=%0h co=%0b ov=%0b want sum=%0h co=%0b ov=%0b",
               name, cur_sum, cur_co, cur_ov, e.sum, e.co, e.ov);
    end
    @(negedge clk);
    checks++;
    if (cur_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%0b want 0", name, cur_done);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #0;
      checks++;
      if (cur_busy !== 1'b0 || cur_done !== 1'b0 || cur_sum !== 64'd0 || cur_co !== 1'b0 ||
          cur_ov !== 1'b0) begin
        errors++;
        $display("FAIL reset_w%0d: got busy=%0b done=%0b sum=%0h co=%0b ov=%0b want all 0",
                 width_of(sel), cur_busy, cur_done, cur_sum, cur_co, cur_ov);
      end
    end
  endtask

  task automatic test_add();
    run_op(2'd0, 64'h0F, 64'h01, 1'b0, "add_0f_01");
    run_op(2'd0, 64'hFF, 64'h01, 1'b0, "add_ff_01");
    run_op(2'd0, 64'h7F, 64'h01, 1'b0, "add_7f_01");
  endtask

  task automatic test_sub();
    run_op(2'd0, 64'h05, 64'h07, 1'b1, "sub_05_07");
    run_op(2'd0, 64'h80, 64'h01, 1'b1, "sub_80_01");
  endtask

  task automatic test_ignore_start();
    int   done_cnt;
    exp_t e;
    sel      = 2'd0;
    a_in     = 64'h11;
    b_in     = 64'h22;
    sub_in   = 1'b0;
    start    = 1'b1;
    done_cnt = 0;
    sb.push_back(model(8, 64'h11, 64'h22, 1'b0));
    @(negedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cur_done) begin
        done_cnt++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          if (cur_sum !== e.sum || cyc != 9) begin
            errors++;
            $display("FAIL ignore_result: got sum=%0h at cycle %0d want sum=%0h at cycle 9",
                     cur_sum, cyc, e.sum);
          end
        end
      end
      start = (cyc == 3);
      if (cyc == 3) begin
        a_in = 64'hAA;
        b_in = 64'hAA;
      end
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d want 1", done_cnt);
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    int   cycles;
    exp_t e;
    sel    = 2'd0;
    a_in   = 64'h10;
    b_in   = 64'h20;
    sub_in = 1'b0;
    start  = 1'b1;
    sb.push_back(model(8, 64'h10, 64'h20, 1'b0));
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!cur_done && cycles <= 12) begin
      @(negedge clk);
      cycles++;
    end
    e = sb.pop_front();
    checks++;
    if (!cur_done || cur_sum !== e.sum) begin
      errors++;
      $display("FAIL b2b_first: got done=%0b sum=%0h want done=1 sum=%0h", cur_done, cur_sum,
               e.sum);
    end
    // Issue the next operation in the done cycle itself.
    a_in  = 64'h01;
    b_in  = 64'h01;
    start = 1'b1;
    sb.push_back(model(8, 64'h01, 64'h01, 1'b0));
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    checks++;
    if (cur_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%0b want 1", cur_busy);
    end
    while (!cur_done && cycles <= 12) begin
      @(negedge clk);
      cycles++;
    end
    e = sb.pop_front();
    checks++;
    if (!cur_done || cycles != 9 || cur_sum !== e.sum) begin
      errors++;
      $display("FAIL b2b_second: got done=%0b cycles=%0d sum=%0h want done=1 cycles=9 sum=%0h",
               cur_done, cycles, cur_sum, e.sum);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int done_cnt;
    sel    = 2'd0;
    a_in   = 64'h55;
    b_in   = 64'h55;
    sub_in = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (cur_busy !== 1'b0 || cur_done !== 1'b0 || cur_sum !== 64'd0 || cur_co !== 1'b0 ||
        cur_ov !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: got busy=%0b done=%0b sum=%0h co=%0b ov=%0b want all 0",
               cur_busy, cur_done, cur_sum, cur_co, cur_ov);
    end
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (cur_done) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d done pulses want 0", done_cnt);
    end
    run_op(2'd0, 64'h03, 64'h04, 1'b0, "after_reset_03_04");
  endtask

  task automatic test_random(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      run_op(s, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
             $sformatf("rand_w%0d_%0d", width_of(s), i));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    sub_in = 1'b0;
    a_in   = '0;
    b_in   = '0;
    sel    = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random(2'd1, 500);
    test_random(2'd2, 500);
    test_random(2'd3, 500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parameterised bit-serial adder/subtractor. It is the sequential successor to the structural half/full adder cells. The block accepts two WIDTH-bit operands on a start pulse, then resolves one bit per clock through a single full-adder cell and a carry flip-flop. Intended for area-constrained datapaths where WIDTH-cycle latency is acceptable.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active low
start  input  1  request pulse; operands sampled when accepted
sub  input  1  0 = a+b, 1 = a-b; sampled with operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result becomes valid
sum  output  WIDTH  result; held stable from done until the next accepted start
carry_out  output  1  add: carry out of MSB; sub: 1 = no borrow (a >= b unsigned)
overflow  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Single clock domain. rst_n is synchronous and active low: sampled on the rising edge of clk; no asynchronous reset path.
- Reset values: busy=0, done=0, sum=0, carry_out=0, overflow=0. FSM state is IDLE, bit counter is 0, carry FF is 0.
- FSM states and transitions:
  - IDLE -> RUN on start=1. Load the A shift register with a. Load the B shift register with b, or ~b when sub=1. Initialise the carry FF to sub. Clear the counter.
  - RUN: each cycle computes s = a_sr[0] ^ b_sr[0] ^ c. It shifts s into the MSB of the result shift register, shifts both operand registers right, updates the carry FF, and increments the counter.
  - RUN -> DONE after the cycle processing bit WIDTH-1. In that cycle, capture the carry into bit WIDTH-1 for overflow, and capture the final carry into carry_out.
  - DONE: done=1 for exactly one cycle, then the FSM moves to IDLE. If start=1 in DONE, the new operation is accepted and the FSM goes directly to RUN (back-to-back issue).
- busy=1 in RUN only. start while in RUN is ignored; operands and outputs are unaffected.
- Latency: start accepted at edge N gives done=1 in the cycle after edge N+WIDTH. Sustained throughput is one result per WIDTH+1 cycles.
- sum, carry_out and overflow update only on the RUN->DONE transition. They hold their values through IDLE and through the next RUN until the next DONE.
- WIDTH=1: RUN lasts one cycle. overflow = carry_in ^ carry_out of that single bit.
- Reset mid-operation (rst_n=0 during RUN): the cycle completes no result. The FSM returns to IDLE and all outputs take their reset values on that edge. No done pulse is generated.
- Arithmetic is modulo 2^WIDTH. No saturation.

Decomposition:
- Shared package serial_adder_pkg holds the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a function returning the counter width, $clog2(WIDTH) with a minimum of 1.
- One sub-module: full_adder_cell, purely combinational. Inputs a, b, cin; outputs s, cout. It is built structurally from two half adders plus an OR gate, and is instantiated once in the datapath.

Test Plan:
- WIDTH=8, add 0x0F+0x01 -> done exactly 9 cycles after the start edge; sum=0x10, carry_out=0, overflow=0; busy high for 8 cycles.
- WIDTH=8, add 0xFF+0x01 -> sum=0x00, carry_out=1, overflow=0. Then add 0x7F+0x01 -> sum=0x80, carry_out=0, overflow=1.
- WIDTH=8, sub 0x05-0x07 -> sum=0xFE, carry_out=0 (borrow), overflow=0. Sub 0x80-0x01 -> sum=0x7F, carry_out=1, overflow=1.
- Pulse start with a=0x11, b=0x22 on the start edge, then pulse start with a=0xAA, b=0xAA in cycle 3 of RUN -> second start is ignored; sum=0x33 and only one done pulse. Start asserted in the done cycle with 0x01+0x01 -> accepted back-to-back; sum=0x02 after 9 further cycles.
- Drive rst_n=0 in cycle 4 of RUN for 0x55+0x55 -> next cycle busy=0, done=0, sum=0x00, carry_out=0, overflow=0; no done pulse follows. A new 0x03+0x04 afterwards -> sum=0x07.
- Parameter sweep WIDTH=1, 16, 64 with 500 random operands and a random sub per operation against a reference model -> sum, carry_out and overflow match every operation; latency is always WIDTH+1.
